instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the single-issue MIPS core. Holds the program counter, reads instruction words from instruction memory over a req/ack handshake, and presents one instruction at a time to the decode stage with a valid/ready handshake. The opcode field feeds the control unit. The block also accepts jump and taken-branch redirects from the execute side, computes the target address, and squashes any in-flight or pending instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction memory read request; held until acknowledged
- imem_addr  out  32  byte address of requested word; bits [1:0] always 0
- imem_ack  in  1  memory acknowledge; imem_rdata valid in same cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc/if_opcode hold a valid instruction
- if_ready  in  1  decode accepts instruction this cycle
- if_instr  out  32  fetched instruction word
- if_opcode  out  6  if_instr[31:26], wired to control unit opcode
- if_pc  out  32  address the instruction was fetched from
- jump  in  1  redirect: unconditional jump resolved this cycle
- branch  in  1  branch instruction resolved this cycle
- taken  in  1  branch condition true; qualifies branch
- redir_pc  in  32  PC of the jump/branch instruction
- redir_imm  in  26  jump target field; low 16 bits are branch offset

## Operation
- States: IDLE, FETCH, VALID. Squash flag SQ tracks a discarded in-flight request.
- Reset (rst=0, asynchronous): pc=RESET_PC, state=IDLE, SQ=0, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0.
- IDLE: goes to FETCH unconditionally on the next edge. imem_req=1, imem_addr=pc.
- FETCH: imem_req=1, and imem_addr is stable until imem_ack. On ack with SQ=0 and no redirect, the block:
  - captures if_instr=imem_rdata and if_pc=pc;
  - sets pc=pc+4;
  - drops imem_req and goes to VALID with if_valid=1.
- VALID: if_valid=1, and data stays stable until if_ready. On if_ready, if_valid=0 and the state goes to FETCH with imem_req=1, imem_addr=pc.
- Redirect condition: redir = jump | (branch & taken).
  - Jump target = {(redir_pc+4)[31:28], redir_imm, 2'b00}.
  - Branch target = redir_pc + 4 + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00}.
  - If jump and branch are both high, jump has priority.
  - branch with taken=0 is ignored.
- Redirect in VALID: pc=target, if_valid=0 (squash), then FETCH. A coincident if_ready is ignored.
- Redirect in FETCH without ack: pc=target and SQ=1. imem_req stays high and imem_addr stays on the old address, because a request is never withdrawn. On the later ack: data is discarded, SQ=0, and imem_addr=pc (the target) next cycle with req still high.
- Redirect in FETCH coincident with ack: data is discarded, pc=target, SQ=0. The block stays in FETCH and imem_addr=target next cycle.
- Redirect in IDLE: pc=target before the first request.
- Arithmetic is modulo 2^32. pc=32'hFFFF_FFFC increments to 0. Branch target addition wraps the same way.

## Timing
- All outputs are registered.
- First imem_req: asserted after the first rising edge with rst=1.
- Ack sampled at edge N: if_valid=1 after edge N. Minimum fetch-to-valid latency is 1 cycle after ack.
- if_ready sampled at edge M: imem_req=1 after edge M. Back-to-back throughput is one instruction per 2 cycles with zero-wait memory.
- Redirect sampled at edge R: squash and the new pc take effect after edge R. If no request is outstanding, the first target request is visible in the cycle after R.
- rst asserted mid-transaction: all state clears immediately. A pending ack after reset release is ignored because the block is in IDLE with req=0.

## Test plan
- Reset release, zero-wait memory, if_ready=1 always: imem_addr sequence 0,4,8,... Each if_valid pulse carries if_pc equal to the requested address. if_opcode equals rdata[31:26].
- Memory stalls 3 cycles before ack: imem_addr is stable and imem_req stays high for 4 cycles. if_valid rises exactly one cycle after ack.
- if_ready=0 for 5 cycles while valid: if_instr/if_pc are held and no new request is issued. Dropping that backpressure triggers a request the next cycle.
- Jump in VALID with redir_pc=0x0040_0010, redir_imm=26'h000_0100: if_valid drops and the next imem_addr is 0x0000_0400.
- Taken branch during an outstanding request, with redir_pc=0x100 and offset 16'hFFFE: the old request completes and its data is discarded (no if_valid). The next imem_addr is 0xFC. A branch with taken=0 changes nothing.
- Wrap and reset: RESET_PC=32'hFFFF_FFFC fetches next from 0. Asserting rst mid-FETCH drops imem_req and if_valid immediately, and the block restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit and its environment.
// It carries the instruction-memory request/ack channel and the
// valid/ready channel to decode.
// master = fetch unit. slave = memory and decode side.
interface instr_fetch_if;
  // Instruction memory channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Decode channel
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    output imem_ack, imem_rdata, if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit for the single-issue MIPS core.
// It holds the PC and reads words from instruction memory over req/ack.
// It hands one instruction at a time to decode over valid/ready.
// Jump and taken-branch redirects from execute squash any in-flight or
// pending instruction.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active-low
  instr_fetch_if.master bus,
  input  logic          jump,
  input  logic          branch,
  input  logic          taken,
  input  logic [31:0]   redir_pc,
  input  logic [25:0]   redir_imm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  // Force word alignment so a mis-set parameter cannot produce an unaligned fetch.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_e      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic        sq_q,        sq_d;        // in-flight request will be discarded
  logic        imem_req_q,  imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        if_valid_q,  if_valid_d;
  logic [31:0] if_instr_q,  if_instr_d;
  logic [31:0] if_pc_q,     if_pc_d;

  logic [31:0] link_pc;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] redir_target;
  logic        redir;

  // Redirect target arithmetic. All sums wrap modulo 2^32.
  // A jump wins over a coincident branch.
  always_comb begin
    link_pc       = redir_pc + 32'd4;
    jump_target   = {link_pc[31:28], redir_imm, 2'b00};
    branch_target = link_pc + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
    redir_target  = jump ? jump_target : branch_target;
    redir         = jump | (branch & taken);
  end

  // Next-state and next-output logic of the fetch FSM
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    sq_d        = sq_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;

    unique case (state_q)
      IDLE: begin
        // The first request goes out on the next edge.
        // A redirect here replaces the PC before anything is requested.
        state_d     = FETCH;
        imem_req_d  = 1'b1;
        if (redir) begin
          pc_d        = redir_target;
          imem_addr_d = redir_target;
        end else begin
          imem_addr_d = pc_q;
        end
      end

      FETCH: begin
        if (bus.imem_ack) begin
          if (redir) begin
            // Returned data belongs to the old path. Refetch from the target at once.
            pc_d        = redir_target;
            sq_d        = 1'b0;
            imem_req_d  = 1'b1;
            imem_addr_d = redir_target;
          end else if (sq_q) begin
            // The squashed request finally completed. Drop it and fetch the
            // redirect target that is already in pc_q.
            sq_d        = 1'b0;
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
          end else begin
            // pc_q equals imem_addr_q whenever sq_q is clear.
            if_instr_d  = bus.imem_rdata;
            if_pc_d     = pc_q;
            if_valid_d  = 1'b1;
            pc_d        = pc_q + 32'd4;
            imem_req_d  = 1'b0;
            state_d     = VALID;
          end
        end else if (redir) begin
          // A request is never withdrawn, so the old address stays on the bus.
          // Its data is discarded when it arrives.
          pc_d = redir_target;
          sq_d = 1'b1;
        end
      end

      VALID: begin
        if (redir) begin
          // Squash the held instruction even if decode is taking it this cycle.
          pc_d        = redir_target;
          if_valid_d  = 1'b0;
          imem_req_d  = 1'b1;
          imem_addr_d = redir_target;
          state_d     = FETCH;
        end else if (bus.if_ready) begin
          if_valid_d  = 1'b0;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
          state_d     = FETCH;
        end
      end

      default: begin
        state_d     = IDLE;
        imem_req_d  = 1'b0;
        if_valid_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs. Reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC_ALIGNED;
      sq_q        <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'h0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= 32'h0;
      if_pc_q     <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      sq_q        <= sq_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_opcode = if_instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch. A memory responder acks a set number of requests
// after a set number of stall cycles.
// The tests push expected request addresses and expected decode-side
// outputs into queues. Independent monitors pop and compare them.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic        jump, branch, taken;
  logic [31:0] redir_pc;
  logic [25:0] redir_imm;

  int n_checks = 0;
  int n_errors = 0;

  int mem_wait  = 0;
  int acks_left = 0;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  instr_fetch_if ifc ();
  instr_fetch_if ifc2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(ifc),
    .jump(jump), .branch(branch), .taken(taken),
    .redir_pc(redir_pc), .redir_imm(redir_imm)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .bus(ifc2),
    .jump(1'b0), .branch(1'b0), .taken(1'b0),
    .redir_pc(32'h0), .redir_imm(26'h0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[7:2], a[25:0] ^ 26'h2AB_CDEF};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expect a request at address a. Optionally expect that word to be presented to decode.
  task automatic push_txn(input logic [31:0] a, input bit presented);
    exp_t e;
    addr_q.push_back(a);
    if (presented) begin
      e.pc    = a;
      e.instr = mem_word(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_req_left"}, 32'(addr_q.size()), 32'd0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    acks_left = 0;
    mem_wait = 0;
    ifc.if_ready = 1'b0;
    jump = 1'b0; branch = 1'b0; taken = 1'b0;
    redir_pc = 32'h0; redir_imm = 26'h0;
    repeat (2) @(negedge clk);
  endtask

  // Memory responder. It also checks each acknowledged address against the request queue.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    ifc.imem_ack = 1'b0;
    ifc.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      ifc.imem_ack = 1'b0;
      if (rst && ifc.imem_req && acks_left > 0) begin
        if (wait_cnt >= mem_wait) begin
          ifc.imem_ack = 1'b1;
          ifc.imem_rdata = mem_word(ifc.imem_addr);
          wait_cnt = 0;
          acks_left--;
          if (addr_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL imem_unexpected_req: got addr %h, expected no request", ifc.imem_addr);
          end else begin
            check("imem_addr", ifc.imem_addr, addr_q.pop_front());
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Decode-side monitor. It compares each newly presented instruction and checks that held data stays put.
  initial begin : monitor
    bit   prev_v;
    exp_t cur;
    prev_v = 1'b0;
    cur.pc = 32'h0;
    cur.instr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
      end else begin
        if (ifc.if_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL if_unexpected: got pc %h instr %h, expected no instruction", ifc.if_pc, ifc.if_instr);
          end else begin
            cur = exp_q.pop_front();
            check("if_pc", ifc.if_pc, cur.pc);
            check("if_instr", ifc.if_instr, cur.instr);
            check("if_opcode", 32'(ifc.if_opcode), 32'(cur.instr[31:26]));
          end
        end else if (ifc.if_valid && prev_v) begin
          check("hold_pc", ifc.if_pc, cur.pc);
          check("hold_instr", ifc.if_instr, cur.instr);
        end
        prev_v = ifc.if_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b0; rst2 = 1'b0;
    ifc.if_ready = 1'b0;
    jump = 1'b0; branch = 1'b0; taken = 1'b0;
    redir_pc = 32'h0; redir_imm = 26'h0;
    ifc2.imem_ack = 1'b1;
    ifc2.imem_rdata = 32'hDEAD_BEEF;
    ifc2.if_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_imem_req", 32'(ifc.imem_req), 32'd0);
    check("rst_imem_addr", ifc.imem_addr, 32'h0);
    check("rst_if_valid", 32'(ifc.if_valid), 32'd0);
    check("rst_if_instr", ifc.if_instr, 32'h0);
    check("rst_if_pc", ifc.if_pc, 32'h0);

    // Zero-wait memory with decode always ready. Sequential addresses 0,4,8,12.
    mem_wait = 0; acks_left = 4; ifc.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_txn(32'(i * 4), 1'b1);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check_drained("seq");
    do_reset();

    // Memory stalls 3 cycles. Address stays stable, and valid comes one cycle after ack.
    mem_wait = 3; acks_left = 1; ifc.if_ready = 1'b1;
    push_txn(32'h0, 1'b1);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_req", 32'(ifc.imem_req), 32'd1);
      check("stall_addr", ifc.imem_addr, 32'h0);
      check("stall_novalid", 32'(ifc.if_valid), 32'd0);
    end
    @(negedge clk);
    check("stall_valid_after_ack", 32'(ifc.if_valid), 32'd1);
    repeat (3) @(negedge clk);
    check_drained("stall");
    do_reset();

    // Backpressure for 5 cycles, with an untaken branch in the middle
    mem_wait = 0; acks_left = 2; ifc.if_ready = 1'b0;
    push_txn(32'h0, 1'b1);
    push_txn(32'h4, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("bp_first_req", 32'(ifc.imem_req), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(ifc.if_valid), 32'd1);
      check("bp_noreq", 32'(ifc.imem_req), 32'd0);
      if (k == 1) begin
        branch = 1'b1; taken = 1'b0; redir_pc = 32'h100; redir_imm = 26'h000_FFFE;
      end else begin
        branch = 1'b0;
      end
    end
    ifc.if_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(ifc.if_valid), 32'd0);
    check("bp_release_req", 32'(ifc.imem_req), 32'd1);
    check("bp_release_addr", ifc.imem_addr, 32'h4);
    repeat (4) @(negedge clk);
    check_drained("bp");
    do_reset();

    // Jump while VALID, with a coincident if_ready. Target is 0x400.
    mem_wait = 0; acks_left = 2; ifc.if_ready = 1'b0;
    push_txn(32'h0, 1'b1);
    push_txn(32'h400, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("jv_valid", 32'(ifc.if_valid), 32'd1);
    jump = 1'b1; redir_pc = 32'h0040_0010; redir_imm = 26'h000_0100; ifc.if_ready = 1'b1;
    @(negedge clk);
    jump = 1'b0; ifc.if_ready = 1'b0;
    check("jv_squash", 32'(ifc.if_valid), 32'd0);
    check("jv_req", 32'(ifc.imem_req), 32'd1);
    check("jv_addr", ifc.imem_addr, 32'h0000_0400);
    repeat (4) @(negedge clk);
    check_drained("jv");
    do_reset();

    // Taken branch while a request is outstanding. Old data is discarded, then fetch resumes at 0xFC.
    mem_wait = 2; acks_left = 2; ifc.if_ready = 1'b1;
    push_txn(32'h0, 1'b0);
    push_txn(32'hFC, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("br_req", 32'(ifc.imem_req), 32'd1);
    branch = 1'b1; taken = 1'b1; redir_pc = 32'h100; redir_imm = 26'h000_FFFE;
    @(negedge clk);
    branch = 1'b0; taken = 1'b0;
    check("br_old_req", 32'(ifc.imem_req), 32'd1);
    check("br_old_addr", ifc.imem_addr, 32'h0);
    @(negedge clk);
    check("br_ack_novalid", 32'(ifc.if_valid), 32'd0);
    @(negedge clk);
    check("br_discard_novalid", 32'(ifc.if_valid), 32'd0);
    check("br_new_req", 32'(ifc.imem_req), 32'd1);
    check("br_new_addr", ifc.imem_addr, 32'h0000_00FC);
    repeat (6) @(negedge clk);
    check_drained("br");
    do_reset();

    // Jump and branch together, coincident with ack. Jump wins and the target is 0x400.
    mem_wait = 0; acks_left = 2; ifc.if_ready = 1'b0;
    push_txn(32'h0, 1'b0);
    push_txn(32'h400, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    jump = 1'b1; branch = 1'b1; taken = 1'b1;
    redir_pc = 32'h0040_0010; redir_imm = 26'h000_0100;
    @(negedge clk);
    jump = 1'b0; branch = 1'b0; taken = 1'b0;
    check("jb_novalid", 32'(ifc.if_valid), 32'd0);
    check("jb_req", 32'(ifc.imem_req), 32'd1);
    check("jb_addr", ifc.imem_addr, 32'h0000_0400);
    repeat (3) @(negedge clk);
    check_drained("jb");
    do_reset();

    // Reset while VALID and while FETCH clears outputs asynchronously
    mem_wait = 0; acks_left = 1; ifc.if_ready = 1'b0;
    push_txn(32'h0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mr_valid_before", 32'(ifc.if_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mr_valid_cleared", 32'(ifc.if_valid), 32'd0);
    check("mr_instr_cleared", ifc.if_instr, 32'h0);
    check("mr_pc_cleared", ifc.if_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_restart_req", 32'(ifc.imem_req), 32'd1);
    check("mr_restart_addr", ifc.imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    check("mr_fetch_req_cleared", 32'(ifc.imem_req), 32'd0);
    check("mr_fetch_addr_cleared", ifc.imem_addr, 32'h0);
    check_drained("mr");

    // PC wrap with RESET_PC = 0xFFFF_FFFC
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    check("wrap_first_req", 32'(ifc2.imem_req), 32'd1);
    check("wrap_first_addr", ifc2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_valid", 32'(ifc2.if_valid), 32'd1);
    check("wrap_if_pc", ifc2.if_pc, 32'hFFFF_FFFC);
    check("wrap_if_instr", ifc2.if_instr, 32'hDEAD_BEEF);
    check("wrap_if_opcode", 32'(ifc2.if_opcode), 32'h37);
    @(negedge clk);
    check("wrap_next_req", 32'(ifc2.imem_req), 32'd1);
    check("wrap_next_addr", ifc2.imem_addr, 32'h0);
    rst2 = 1'b0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
